prefix_adder_pipe: RTL and testbench

Parametrised, fully pipelined parallel-prefix (recursive-doubling) adder/subtractor with a valid/ready handshake on both sides. It accepts one operation per cycle. Each doubling level of the generate/propagate prefix tree sits in its own register stage. It is the datapath adder for the multiplier's final carry-propagate stage and for accumulators that need a registered, back-pressurable sum.

---
 rtl/prefix_adder_pipe_if.sv | 27 ++
 rtl/prefix_adder_pipe.sv | 55 +++++
 tb/tb_prefix_adder_pipe.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefix_adder_pipe_if.sv
// prefix_adder_pipe_if: operand/result handshake bundle for prefix_adder_pipe
interface prefix_adder_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic [TAG_W-1:0] tag_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic [TAG_W-1:0] tag_out;
   modport master (
      output in_valid, a, b, cin, sub, tag_in, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, tag_out
   );
   modport slave (
      input  in_valid, a, b, cin, sub, tag_in, out_ready,
      output in_ready, out_valid, sum, cout, ovf, tag_out
   );
endinterface

// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined recursive-doubling adder/subtractor, one prefix level per stage
module prefix_adder_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input logic clk,
   input logic rst,
   prefix_adder_pipe_if.slave bus
);
   localparam int LVL = $clog2(WIDTH);
   logic             en;
   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] gen_r  [LVL+1];
   logic [WIDTH-1:0] prop_r [LVL+1];
   logic [WIDTH-1:0] p_r    [LVL+1];
   logic [TAG_W-1:0] tag_r  [LVL+1];
   logic             c0_r   [LVL+1];
   logic             vld_r  [LVL+1];
   assign en = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = en;
   assign bx = bus.sub ? ~bus.b : bus.b;
   // carry into bit i is the group generate of bit i-1; c0 feeds bit 0
   assign carry = {gen_r[LVL][WIDTH-2:0], c0_r[LVL]};
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= LVL; k++) vld_r[k] <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.sum <= '0;
         bus.cout <= 1'b0;
         bus.ovf <= 1'b0;
         bus.tag_out <= '0;
      end else if (en) begin
         vld_r[0] <= bus.in_valid;
         p_r[0] <= bus.a ^ bx;
         prop_r[0] <= bus.a ^ bx;
         gen_r[0] <= (bus.a & bx) | WIDTH'((bus.a[0] ^ bx[0]) & (bus.sub | bus.cin));
         c0_r[0] <= bus.sub | bus.cin;
         tag_r[0] <= bus.tag_in;
         for (int k = 1; k <= LVL; k++) begin
            gen_r[k] <= gen_r[k-1] | (prop_r[k-1] & (gen_r[k-1] << (1 << (k-1))));
            prop_r[k] <= prop_r[k-1] & ((prop_r[k-1] << (1 << (k-1))) | ~({WIDTH{1'b1}} << (1 << (k-1))));
            p_r[k] <= p_r[k-1];
            c0_r[k] <= c0_r[k-1];
            tag_r[k] <= tag_r[k-1];
            vld_r[k] <= vld_r[k-1];
         end
         bus.out_valid <= vld_r[LVL];
         bus.sum <= p_r[LVL] ^ carry;
         bus.cout <= gen_r[LVL][WIDTH-1];
         bus.ovf <= gen_r[LVL][WIDTH-1] ^ gen_r[LVL][WIDTH-2];
         bus.tag_out <= tag_r[LVL];
      end
   end
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// tb_prefix_adder_pipe: drives 8/32/64-bit instances against an arithmetic scoreboard model
module tb_prefix_adder_pipe;
   typedef struct {
      logic [63:0] s;
      logic        c;
      logic        o;
      logic [3:0]  t;
      int          cyc;
   } exp_t;
   localparam int WD  [3] = '{8, 32, 64};
   localparam int LAT [3] = '{5, 7, 8};
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic        iv [3];
   logic [63:0] ia [3];
   logic [63:0] ib [3];
   logic        ici [3];
   logic        isb [3];
   logic [3:0]  itg [3];
   logic        ordy [3];
   logic        ird [3];
   logic        ov [3];
   logic [63:0] os [3];
   logic        oc [3];
   logic        oo [3];
   logic [3:0]  ot [3];
   logic [3:0]  tagc [3];
   logic        acc [3];
   logic        stall [3];
   logic [63:0] hs [3];
   logic        hc [3];
   logic        ho [3];
   logic [3:0]  ht [3];
   exp_t        sb [3][$];
   int          tot = 0;
   int          pass = 0;
   int          cyc = 0;
   logic        lat_chk = 1'b0;
   prefix_adder_pipe_if #(.WIDTH(8),  .TAG_W(4)) b8 ();
   prefix_adder_pipe_if #(.WIDTH(32), .TAG_W(4)) b32 ();
   prefix_adder_pipe_if #(.WIDTH(64), .TAG_W(4)) b64 ();
   prefix_adder_pipe #(.WIDTH(8),  .TAG_W(4)) d8  (.clk(clk), .rst(rst), .bus(b8));
   prefix_adder_pipe #(.WIDTH(32), .TAG_W(4)) d32 (.clk(clk), .rst(rst), .bus(b32));
   prefix_adder_pipe #(.WIDTH(64), .TAG_W(4)) d64 (.clk(clk), .rst(rst), .bus(b64));
   assign b8.in_valid = iv[0];
   assign b8.a = ia[0][7:0];
   assign b8.b = ib[0][7:0];
   assign b8.cin = ici[0];
   assign b8.sub = isb[0];
   assign b8.tag_in = itg[0];
   assign b8.out_ready = ordy[0];
   assign b32.in_valid = iv[1];
   assign b32.a = ia[1][31:0];
   assign b32.b = ib[1][31:0];
   assign b32.cin = ici[1];
   assign b32.sub = isb[1];
   assign b32.tag_in = itg[1];
   assign b32.out_ready = ordy[1];
   assign b64.in_valid = iv[2];
   assign b64.a = ia[2];
   assign b64.b = ib[2];
   assign b64.cin = ici[2];
   assign b64.sub = isb[2];
   assign b64.tag_in = itg[2];
   assign b64.out_ready = ordy[2];
   always_comb begin
      ird[0] = b8.in_ready;
      ov[0] = b8.out_valid;
      os[0] = 64'(b8.sum);
      oc[0] = b8.cout;
      oo[0] = b8.ovf;
      ot[0] = b8.tag_out;
      ird[1] = b32.in_ready;
      ov[1] = b32.out_valid;
      os[1] = 64'(b32.sum);
      oc[1] = b32.cout;
      oo[1] = b32.ovf;
      ot[1] = b32.tag_out;
      ird[2] = b64.in_ready;
      ov[2] = b64.out_valid;
      os[2] = b64.sum;
      oc[2] = b64.cout;
      oo[2] = b64.ovf;
      ot[2] = b64.tag_out;
   end
   // plain w-bit arithmetic; overflow from operand/result signs
   function automatic exp_t model(input logic [63:0] a, b, input logic ci, s, input int w);
      logic [64:0] full;
      logic [63:0] m, bb;
      exp_t e;
      m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
      bb = (s ? ~b : b) & m;
      full = {1'b0, a & m} + {1'b0, bb} + 65'(s | ci);
      e.s = full[63:0] & m;
      e.c = full[w];
      e.o = (a[w-1] == bb[w-1]) && (e.s[w-1] != a[w-1]);
      e.t = '0;
      e.cyc = 0;
      return e;
   endfunction
   task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] want);
      tot++;
      if (act === want) pass++;
      else $display("FAIL %s dut%0d: got %0h want %0h at t=%0t", nm, d, act, want, $time);
   endtask
   task automatic gen(input int d);
      ia[d] = {$urandom, $urandom};
      ib[d] = ($urandom_range(0, 3) == 0) ? ~ia[d] : {$urandom, $urandom};
      ici[d] = 1'($urandom_range(0, 1));
      isb[d] = 1'($urandom_range(0, 1));
      itg[d] = tagc[d];
      tagc[d]++;
   endtask
   task automatic directed(input int d, input logic [63:0] a, b, input logic ci, s,
                           input logic [63:0] es, input logic ec, eo);
      int n;
      exp_t m;
      m = model(a, b, ci, s, WD[d]);
      chk("model_sum", d, m.s, es);
      chk("model_cout", d, m.c, ec);
      chk("model_ovf", d, m.o, eo);
      iv[d] = 1'b1; ia[d] = a; ib[d] = b; ici[d] = ci; isb[d] = s;
      itg[d] = tagc[d];
      tagc[d]++;
      @(posedge clk); #1;
      iv[d] = 1'b0;
      n = 1;
      while (!ov[d] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("dir_latency", d, n, LAT[d]);
      chk("dir_sum", d, os[d], es);
      chk("dir_cout", d, oc[d], ec);
      chk("dir_ovf", d, oo[d], eo);
      @(posedge clk); #1;
   endtask
   task automatic reset_state;
      for (int d = 0; d < 3; d++) begin
         chk("rst_valid", d, ov[d], 0);
         chk("rst_sum", d, os[d], 0);
         chk("rst_cout", d, oc[d], 0);
         chk("rst_ovf", d, oo[d], 0);
         chk("rst_tag", d, ot[d], 0);
         chk("rst_in_ready", d, ird[d], 1);
      end
   endtask
   task automatic drain;
      for (int d = 0; d < 3; d++) iv[d] = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) chk("drained", d, sb[d].size(), 0);
   endtask
   // scoreboard: push on input handshake, pop on output handshake, checks every cycle
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            sb[d].delete();
            stall[d] = 1'b0;
            acc[d] = 1'b0;
         end else begin
            chk("in_ready", d, ird[d], !ov[d] || ordy[d]);
            if (stall[d]) begin
               chk("hold_valid", d, ov[d], 1);
               chk("hold_sum", d, os[d], hs[d]);
               chk("hold_cout", d, oc[d], hc[d]);
               chk("hold_ovf", d, oo[d], ho[d]);
               chk("hold_tag", d, ot[d], ht[d]);
            end
            if (ov[d] && ordy[d]) begin
               chk("have_expected", d, sb[d].size() != 0, 1);
               if (sb[d].size() != 0) begin
                  e = sb[d].pop_front();
                  chk("sum", d, os[d], e.s);
                  chk("cout", d, oc[d], e.c);
                  chk("ovf", d, oo[d], e.o);
                  chk("tag", d, ot[d], e.t);
                  if (lat_chk) chk("latency", d, cyc - e.cyc, LAT[d]);
               end
            end
            acc[d] = iv[d] && ird[d];
            if (acc[d]) begin
               e = model(ia[d], ib[d], ici[d], isb[d], WD[d]);
               e.t = itg[d];
               e.cyc = cyc;
               sb[d].push_back(e);
            end
            stall[d] = ov[d] && !ordy[d];
            hs[d] = os[d];
            hc[d] = oc[d];
            ho[d] = oo[d];
            ht[d] = ot[d];
         end
      end
   end
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end
   initial begin
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; ia[d] = '0; ib[d] = '0; ici[d] = 1'b0; isb[d] = 1'b0;
         itg[d] = '0; ordy[d] = 1'b1; tagc[d] = '0; acc[d] = 1'b0; stall[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      reset_state();
      rst = 1'b0;
      directed(1, 64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      directed(1, 64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000, 1'b0, 1'b1);
      directed(1, 64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0);
      directed(1, 64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0);
      directed(1, 64'h80000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFF, 1'b1, 1'b1);
      directed(1, 64'h0000FFFF, 64'h0, 1'b1, 1'b0, 64'h00010000, 1'b0, 1'b0);
      directed(0, 64'hFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      directed(0, 64'h7F, 64'h1, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1);
      directed(0, 64'h80, 64'h1, 1'b1, 1'b1, 64'h7F, 1'b1, 1'b1);
      directed(2, 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      directed(2, 64'h7FFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b0, 64'h8000000000000000, 1'b0, 1'b1);
      // back-to-back streaming with latency checked per result
      lat_chk = 1'b1;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b1;
         gen(d);
      end
      repeat (1000) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) gen(d);
      end
      drain();
      lat_chk = 1'b0;
      // random gaps plus a 5-cycle stall, then random backpressure
      for (int c = 0; c < 800; c++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) begin
            if (acc[d] || !iv[d]) begin
               iv[d] = $urandom_range(0, 3) != 0;
               if (iv[d]) gen(d);
            end
            ordy[d] = (c >= 100 && c < 105) ? 1'b0 : (c >= 400) ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) ordy[d] = 1'b1;
      drain();
      // four ops in flight, then reset
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b1;
         gen(d);
      end
      repeat (3) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) gen(d);
      end
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) iv[d] = 1'b0;
      chk("inflight", 1, sb[1].size(), 4);
      rst = 1'b1;
      @(posedge clk); #1;
      reset_state();
      rst = 1'b0;
      drain();
      // 8-bit sweep: all A, a spread of B, add cin=0/1 and subtract
      iv[0] = 1'b1;
      for (int m = 0; m < 3; m++) begin
         for (int x = 0; x < 256; x++) begin
            for (int y = 0; y < 32; y++) begin
               ia[0] = 64'(x);
               ib[0] = {56'd0, y[4:0], 3'($urandom_range(0, 7))};
               ici[0] = (m == 2) ? 1'($urandom_range(0, 1)) : (m == 1);
               isb[0] = (m == 2);
               itg[0] = tagc[0];
               tagc[0]++;
               @(posedge clk); #1;
            end
         end
      end
      drain();
      $display("%0d/%0d checks passed", pass, tot);
      $finish;
   end
endmodule
